mem_parity_err_gen: RTL and testbench

// - Memory-side source of the error-detect signals consumed by the duplex error detection/switchover logic.
// - Serially walks one memory syllable (data bits, then one parity bit), with one bit per BIT_EN.
// - Read mode: checks odd parity on both duplex copies (X, Y) and flags any X/Y bit disagreement.

---
 rtl/mem_parity_err_gen.sv | 165 ++++++++++++++++
 tb/tb_mem_parity_err_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_parity_err_gen.sv
// Serial odd-parity checker/generator for one duplex memory syllable.
// Read mode produces held EDX/EDY/EP/MISCMP levels; write mode emits the parity bit.
module mem_parity_err_gen #(
    parameter int SYL_BITS = 13,
    parameter int CNT_W    = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic bit_en_i,
    input  logic syl_start_i,
    input  logic read_i,
    input  logic sdx_i,
    input  logic sdy_i,
    input  logic wdata_i,
    output logic wpar_o,
    output logic wpar_vld_o,
    output logic edx_o,
    output logic edy_o,
    output logic ep_o,
    output logic miscmp_o,
    output logic busy_o,
    output logic done_o
);

    // state    | meaning
    // IDLE     | waiting for SYL_START with BIT_EN
    // DATA     | absorbing data bits 1..SYL_BITS-1
    // PARITY   | waiting for the parity slot; WPAR valid on writes
    // REPORT   | one-CLK DONE; read flags just updated
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(SYL_BITS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             acc_x_q, acc_x_d;
    logic             acc_y_q, acc_y_d;
    logic             mis_q, mis_d;
    logic             edx_q, edx_d;
    logic             edy_q, edy_d;
    logic             ep_q, ep_d;
    logic             miscmp_q, miscmp_d;
    logic             accept;
    logic             bit_x;

    assign accept = bit_en_i & syl_start_i;
    // acc_x doubles as the write-data accumulator in write mode
    assign bit_x  = mode_q ? sdx_i : wdata_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        mis_d    = mis_q;
        edx_d    = edx_q;
        edy_d    = edy_q;
        ep_d     = ep_q;
        miscmp_d = miscmp_q;

        if (accept) begin
            // A new start in any state aborts or follows the current syllable
            state_d  = S_DATA;
            cnt_d    = CNT_W'(1);
            mode_d   = read_i;
            acc_x_d  = read_i ? sdx_i : wdata_i;
            acc_y_d  = sdy_i;
            mis_d    = sdx_i ^ sdy_i;
            edx_d    = 1'b0;
            edy_d    = 1'b0;
            ep_d     = 1'b0;
            miscmp_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_DATA: begin
                    if (bit_en_i) begin
                        acc_x_d = acc_x_q ^ bit_x;
                        acc_y_d = acc_y_q ^ sdy_i;
                        mis_d   = mis_q | (sdx_i ^ sdy_i);
                        if (cnt_q == LAST_DATA) begin
                            state_d = S_PARITY;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_en_i) begin
                        state_d = S_REPORT;
                        if (mode_q) begin
                            edx_d    = ~(acc_x_q ^ sdx_i);
                            edy_d    = ~(acc_y_q ^ sdy_i);
                            ep_d     = ~(acc_x_q ^ sdx_i) & ~(acc_y_q ^ sdy_i);
                            miscmp_d = mis_q | (sdx_i ^ sdy_i);
                        end
                    end
                end
                S_REPORT: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    acc_x_d = 1'b0;
                    acc_y_d = 1'b0;
                    mis_d   = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            acc_x_q  <= 1'b0;
            acc_y_q  <= 1'b0;
            mis_q    <= 1'b0;
            edx_q    <= 1'b0;
            edy_q    <= 1'b0;
            ep_q     <= 1'b0;
            miscmp_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
            mis_q    <= mis_d;
            edx_q    <= edx_d;
            edy_q    <= edy_d;
            ep_q     <= ep_d;
            miscmp_q <= miscmp_d;
        end
    end

    assign busy_o     = (state_q == S_DATA) | (state_q == S_PARITY);
    assign done_o     = (state_q == S_REPORT);
    assign wpar_vld_o = (state_q == S_PARITY) & ~mode_q;
    assign wpar_o     = wpar_vld_o & ~acc_x_q;
    assign edx_o      = edx_q;
    assign edy_o      = edy_q;
    assign ep_o       = ep_q;
    assign miscmp_o   = miscmp_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (state_q inside {S_IDLE, S_DATA, S_PARITY, S_REPORT})
                else $error("illegal state %0d", state_q);
            assert (cnt_q <= LAST_DATA)
                else $error("bit count out of range %0d", cnt_q);
        end
    end
`endif

endmodule

// File: tb/tb_mem_parity_err_gen.sv
// Directed bench for mem_parity_err_gen: expected flag sets and DONE edges are
// queued per syllable and checked when DONE appears.
module tb_mem_parity_err_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_en = 1'b0, syl_start = 1'b0, rd_in = 1'b0;
    logic sdx = 1'b0, sdy = 1'b0, wdata = 1'b0;
    logic wpar_o, wpar_vld_o, edx_o, edy_o, ep_o, miscmp_o, busy_o, done_o;

    int compared = 0;
    int mismatched = 0;
    int n_edge = 0;

    typedef struct {
        logic edx;
        logic edy;
        logic ep;
        logic mis;
        int   done_edge;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_parity_err_gen #(.SYL_BITS(13), .CNT_W(4)) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .bit_en_i   (bit_en),
        .syl_start_i(syl_start),
        .read_i     (rd_in),
        .sdx_i      (sdx),
        .sdy_i      (sdy),
        .wdata_i    (wdata),
        .wpar_o     (wpar_o),
        .wpar_vld_o (wpar_vld_o),
        .edx_o      (edx_o),
        .edy_o      (edy_o),
        .ep_o       (ep_o),
        .miscmp_o   (miscmp_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic step(input logic be, input logic ss, input logic r,
                        input logic x, input logic y, input logic w);
        exp_t e;
        bit_en = be; syl_start = ss; rd_in = r; sdx = x; sdy = y; wdata = w;
        @(posedge clk);
        n_edge++;
        #1;
        if (done_o === 1'b1) begin
            chkv("done_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk1("edx", edx_o, e.edx);
                chk1("edy", edy_o, e.edy);
                chk1("ep", ep_o, e.ep);
                chk1("miscmp", miscmp_o, e.mis);
                chkv("done_edge", n_edge, e.done_edge);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // nbits < 14 sends a truncated syllable that must never produce DONE.
    task automatic send_syl(input logic rd, input logic [12:0] dx, input logic [12:0] dy,
                            input logic px, input logic py, input logic [12:0] wd,
                            input int gap, input int nbits);
        exp_t e;
        logic [13:0] fx, fy, fw;
        logic exp_vld, exp_wpar;
        fx = {px, dx};
        fy = {py, dy};
        fw = {1'b0, wd};
        exp_vld  = !rd;
        exp_wpar = !rd && !(^wd);
        if (nbits == 14) begin
            e.edx = rd & ~(^fx);
            e.edy = rd & ~(^fy);
            e.ep  = e.edx & e.edy;
            e.mis = rd & (fx != fy);
            e.done_edge = n_edge + 1 + 13 * (gap + 1);
            sb.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i > 0)
                for (int g = 0; g < gap; g++)
                    step(1'b0, 1'b1, !rd, 1'($urandom), 1'($urandom), 1'($urandom));
            if (i == 13) begin
                chk1("busy_parity", busy_o, 1'b1);
                chk1("wpar_vld", wpar_vld_o, exp_vld);
                chk1("wpar", wpar_o, exp_wpar);
            end
            step(1'b1, i == 0, rd, rd ? fx[i] : 1'b0, rd ? fy[i] : 1'b0, fw[i]);
            if (i == 0) chk1("busy_start", busy_o, 1'b1);
        end
        if (nbits == 14) chk1("done_pulse", done_o, 1'b1);
    endtask

    initial begin
        // Reset state
        idle(2);
        chkv("reset_outputs", 32'({wpar_o, wpar_vld_o, edx_o, edy_o, ep_o, miscmp_o, busy_o, done_o}), 32'd0);
        rst = 1'b0;
        idle(2);
        chkv("idle_outputs", 32'({wpar_o, wpar_vld_o, busy_o, done_o}), 32'd0);

        // Clean read
        send_syl(1'b1, 13'h0001, 13'h0001, 1'b0, 1'b0, 13'h0AAA, 0, 14);
        idle(1);
        chk1("report_to_idle", busy_o | done_o, 1'b0);

        // X even parity, Y good, parity bits differ
        send_syl(1'b1, 13'h0003, 13'h0003, 1'b0, 1'b1, 13'h0000, 0, 14);
        idle(1);
        send_syl(1'b1, 13'h1FFF, 13'h1FFF, 1'b0, 1'b0, 13'h0000, 0, 14);
        idle(1);
        send_syl(1'b1, 13'h1FFF, 13'h1FFF, 1'b1, 1'b1, 13'h0000, 0, 14);
        idle(1);
        chkv("flags_held", 32'({edx_o, edy_o, ep_o, miscmp_o}), 32'b1110);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chkv("flags_held_bit_en", 32'({edx_o, edy_o, ep_o, miscmp_o, busy_o}), 32'b11100);

        // Writes, continuous and with BIT_EN every 3rd clock
        send_syl(1'b0, 13'h0000, 13'h0000, 1'b0, 1'b0, 13'h0005, 0, 14);
        idle(1);
        send_syl(1'b0, 13'h0000, 13'h0000, 1'b0, 1'b0, 13'h0005, 2, 14);
        idle(1);
        send_syl(1'b0, 13'h0000, 13'h0000, 1'b0, 1'b0, 13'h1FFF, 0, 14);
        idle(1);

        // Abort after 6 data bits, then a full syllable
        send_syl(1'b1, 13'h1FFF, 13'h1FFF, 1'b1, 1'b1, 13'h0000, 0, 14);
        send_syl(1'b1, 13'h0F0F, 13'h0F0E, 1'b0, 1'b0, 13'h0000, 0, 6);
        chkv("abort_flags_clear", 32'({edx_o, edy_o, ep_o, miscmp_o}), 32'd0);
        send_syl(1'b1, 13'h0AAA, 13'h0AAB, 1'b1, 1'b0, 13'h0000, 0, 14);
        idle(1);

        // Reset at bit 9 of a write
        send_syl(1'b0, 13'h0000, 13'h0000, 1'b0, 1'b0, 13'h0123, 0, 9);
        chk1("busy_before_reset", busy_o, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chkv("reset_mid_syl", 32'({wpar_o, wpar_vld_o, edx_o, edy_o, ep_o, miscmp_o, busy_o, done_o}), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk1("idle_after_reset", busy_o, 1'b0);

        // Back-to-back syllables, each starting in the previous REPORT cycle
        send_syl(1'b1, 13'h1234, 13'h1234, 1'b0, 1'b0, 13'h0000, 0, 14);
        send_syl(1'b0, 13'h0000, 13'h0000, 1'b0, 1'b0, 13'h1FFF, 0, 14);
        send_syl(1'b1, 13'h0F0F, 13'h0F0E, 1'b0, 1'b0, 13'h0000, 0, 14);
        send_syl(1'b1, 13'($urandom), 13'($urandom), 1'($urandom), 1'($urandom), 13'($urandom), 1, 14);
        idle(3);
        chkv("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
